// File: rtl/regfile_wb_scheduler_if.sv
// Writeback, register-file write port and hazard-check signals shared between
// the writeback scheduler and its surrounding pipeline.
interface regfile_wb_scheduler_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic [AW-1:0]   rf_rd;
    logic            rf_wen;
    logic [XLEN-1:0] rf_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic [AW-1:0]   chk_rs1_addr;
    logic [AW-1:0]   chk_rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd, chk_rs1_addr, chk_rs2_addr,
        input  alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
        input  rf_rd, rf_wen, rf_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd, chk_rs1_addr, chk_rs2_addr,
        output alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
        output rf_rd, rf_wen, rf_data
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin scheduler for the single register-file write port (ALU vs LSU)
// with a busy scoreboard used by issue for RAW/WAW stalls.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    regfile_wb_scheduler_if.slave wb
);
    localparam int NREG = 2 ** AW;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e          last_grant_r;
    grant_e          last_grant_nxt_s;
    logic            alu_gnt_s;
    logic            lsu_gnt_s;
    logic            hs_s;
    logic [AW-1:0]   gnt_rd_s;
    logic [XLEN-1:0] gnt_data_s;
    logic [AW-1:0]   rf_rd_r;
    logic            rf_wen_r;
    logic [XLEN-1:0] rf_data_r;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic            iss_ready_s;

    // Grant selection and next round-robin pointer; a tie goes to the requester not served last.
    always_comb begin
        alu_gnt_s        = 1'b0;
        lsu_gnt_s        = 1'b0;
        last_grant_nxt_s = last_grant_r;
        if (wb.alu_valid && wb.lsu_valid) begin
            if (last_grant_r == GRANT_ALU) begin
                lsu_gnt_s = 1'b1;
            end else begin
                alu_gnt_s = 1'b1;
            end
        end else if (wb.alu_valid) begin
            alu_gnt_s = 1'b1;
        end else if (wb.lsu_valid) begin
            lsu_gnt_s = 1'b1;
        end else begin
            alu_gnt_s = 1'b0;
            lsu_gnt_s = 1'b0;
        end
        if (alu_gnt_s) begin
            last_grant_nxt_s = GRANT_ALU;
        end else if (lsu_gnt_s) begin
            last_grant_nxt_s = GRANT_LSU;
        end else begin
            last_grant_nxt_s = last_grant_r;
        end
    end

    assign hs_s       = alu_gnt_s | lsu_gnt_s;
    assign gnt_rd_s   = lsu_gnt_s ? wb.lsu_rd   : wb.alu_rd;
    assign gnt_data_s = lsu_gnt_s ? wb.lsu_data : wb.alu_data;

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_r <= GRANT_ALU;
        end else begin
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // Registered write port; an x0 destination completes the handshake without a write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_rd_r   <= {AW{1'b0}};
            rf_wen_r  <= 1'b0;
            rf_data_r <= {XLEN{1'b0}};
        end else if (hs_s) begin
            rf_rd_r   <= gnt_rd_s;
            rf_wen_r  <= (gnt_rd_s != {AW{1'b0}});
            rf_data_r <= gnt_data_s;
        end else begin
            rf_wen_r  <= 1'b0;
        end
    end

    assign iss_ready_s = ~busy_r[wb.iss_rd];

    // Scoreboard update: clear on commit, set on accepted claim; a claim never targets a busy
    // register, so the two never collide.
    always_comb begin
        busy_nxt_s = busy_r;
        if (rf_wen_r) begin
            busy_nxt_s[rf_rd_r] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (wb.iss_valid && iss_ready_s && (wb.iss_rd != {AW{1'b0}})) begin
            busy_nxt_s[wb.iss_rd] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign wb.alu_ready = alu_gnt_s;
    assign wb.lsu_ready = lsu_gnt_s;
    assign wb.rf_rd     = rf_rd_r;
    assign wb.rf_wen    = rf_wen_r;
    assign wb.rf_data   = rf_data_r;
    assign wb.iss_ready = iss_ready_s;
    assign wb.rs1_busy  = busy_r[wb.chk_rs1_addr];
    assign wb.rs2_busy  = busy_r[wb.chk_rs2_addr];

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single write port of riscv_registers between two writeback requesters: ALU and load/store unit (LSU).
- Arbitrates round-robin with valid/ready handshakes and drives the register file write port (rd, wen, data) from a registered output stage.
- Keeps a busy scoreboard of registers with outstanding writes so the issue stage can stall on RAW and WAW hazards.

Parameters:
- XLEN, 32, data width of a writeback value.
- AW, 5, register address width; 2**AW registers; x0 is hardwired zero.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request granted this cycle.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  XLEN  LSU load data.
- rf_rd  out  AW  register file write address.
- rf_wen  out  1  register file write enable.
- rf_data  out  XLEN  register file write data.
- iss_valid  in  1  issue stage claims a destination register.
- iss_rd  in  AW  destination being claimed.
- iss_ready  out  1  claim accepted; 0 means WAW stall.
- chk_rs1_addr  in  AW  source 1 address for the hazard check.
- chk_rs2_addr  in  AW  source 2 address for the hazard check.
- rs1_busy  out  1  source 1 has a pending write.
- rs2_busy  out  1  source 2 has a pending write.

Behaviour:
- Reset (rstn=0, asynchronous):
  - rf_wen=0, rf_rd=0, rf_data=0.
  - busy vector = all 0.
  - last_grant = ALU.
  - Any request in flight is dropped. Reset mid-operation discards a registered-but-uncommitted write: rf_wen falls immediately.
- Arbitration (combinational grant):
  - Only one valid: that one is granted.
  - Both valid: the requester not in last_grant is granted. After reset, the first tie goes to LSU.
  - alu_ready/lsu_ready = grant to that requester. A ready never asserts without the matching valid.
  - A handshake is valid && ready. last_grant updates only on a handshake.
  - An ungranted requester holds valid/rd/data stable until granted; it waits at most one cycle under continuous contention.
- Output stage:
  - On a handshake edge: rf_rd <= granted rd, rf_data <= granted data, rf_wen <= (granted rd != 0).
  - No handshake: rf_wen <= 0; rf_rd/rf_data hold.
  - riscv_registers commits on the edge after the handshake, so handshake-to-commit latency is 1 cycle. Back-to-back handshakes give one write per cycle.
- x0 writes complete the handshake normally, never assert rf_wen, and never touch the scoreboard.
- Scoreboard:
  - busy[0] is constantly 0.
  - Set: busy[iss_rd] <= 1 on an edge with iss_valid && iss_ready && iss_rd != 0.
  - Clear: busy[rf_rd] <= 0 on an edge with rf_wen=1, the same edge the register file commits.
  - iss_ready = !busy[iss_rd] (combinational). Claiming a busy register stalls, which guarantees set and clear never target the same register on one edge.
  - Set and clear of different registers on the same edge both take effect.
  - A claim stalled because busy is still set in the commit cycle is accepted the following cycle.
  - rsN_busy = busy[chk_rsN_addr], combinational. It drops in the cycle after commit, when riscv_registers already returns the new value.
- Writeback to a non-busy register: the write proceeds and the clear is a no-op. This is not an error.

Test Plan:
- Reset, then alu_valid=1, alu_rd=1, alu_data=69 for one cycle -> alu_ready=1 that cycle; next cycle rf_wen=1, rf_rd=1, rf_data=69; the cycle after, rf_wen=0.
- Reset, then alu_valid=lsu_valid=1 held with (rd 2, 0xA) and (rd 3, 0xB) -> grants LSU first, then ALU; rf_wen high 2 consecutive cycles with rd 3/0xB then 2/0xA.
- iss_valid=1, iss_rd=5 -> busy[5] set; chk_rs1_addr=5 gives rs1_busy=1; LSU writes rd 5 value 23 -> rs1_busy stays 1 through the commit cycle, 0 the next.
- With busy[5]=1: iss_rd=5 -> iss_ready=0 until the rd 5 commit; iss_ready=1 the cycle after, and busy[5] is re-set.
- alu_rd=0, alu_data=0xFFFFFFFF -> alu_ready=1, rf_wen stays 0; iss_rd=0 -> iss_ready=1, rs1_busy for addr 0 stays 0.
- Claim rd 7, handshake a write to 7, pull rstn low for 1 cycle before commit -> rf_wen=0 immediately, busy all 0, iss_ready=1 for rd 7 after reset.
